// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready, stall, flush-to-bubble and a stall counter.
// Define PIPE_SKID_EN to add a one-entry skid buffer so in_ready no longer depends on out_ready.
module pipe_stage_reg #(
    parameter int                 DATA_W      = 32,
    parameter int                 CTRL_W      = 13,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
    parameter int                 CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, drain;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // Ready comes from the skid flop; out_ready never reaches in_ready.
    assign in_ready = rst & ~stall & ~flush & ~skid_valid_q;
`else
    assign in_ready = rst & ~stall & ~flush & (~out_valid_q | out_ready);
`endif

    always_comb begin
        accept      = in_valid & in_ready;
        drain       = out_valid_q & out_ready;
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
`ifdef PIPE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
            ctrl_d      = CTRL_BUBBLE;
`ifdef PIPE_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end else begin
`ifdef PIPE_SKID_EN
            if (out_valid_q && !out_ready) begin
                if (accept) begin
                    skid_valid_d = 1'b1;
                    skid_ctrl_d  = in_ctrl;
                    skid_data_d  = in_data;
                end
            end else if (skid_valid_q) begin
                // Intake is blocked while the skid is full, so it always refills main first.
                out_valid_d  = 1'b1;
                ctrl_d       = skid_ctrl_q;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                ctrl_d      = in_ctrl;
                data_d      = in_data;
            end else if (drain) begin
                out_valid_d = 1'b0;
                ctrl_d      = CTRL_BUBBLE;
            end
`else
            if (accept) begin
                out_valid_d = 1'b1;
                ctrl_d      = in_ctrl;
                data_d      = in_data;
            end else if (drain) begin
                out_valid_d = 1'b0;
                ctrl_d      = CTRL_BUBBLE;
            end
`endif
        end
        if ((stall || (out_valid_q && !out_ready)) && !flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= CTRL_BUBBLE;
            data_q      <= '0;
            cnt_q       <= '0;
`ifdef PIPE_SKID_EN
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= CTRL_BUBBLE;
            skid_data_q  <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
`ifdef PIPE_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors push expected entries, a monitor checks drains.
// Expectations follow PIPE_SKID_EN when it is defined for the build.
module tb_pipe_stage_reg;
    localparam int            DW  = 32;
    localparam int            CW  = 13;
    localparam int            NW  = 4;
    localparam logic [CW-1:0] BUB = 13'h0A5;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, stall, flush, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [NW-1:0] stall_cnt;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .stall_cnt(stall_cnt)
    );

    function automatic logic [CW-1:0] ctl(input logic [DW-1:0] d);
        return d[CW-1:0] ^ 13'h1F0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check pre-edge state at negedge, then take the edge.
    task automatic vec(input bit iv, input logic [DW-1:0] d, input bit st, input bit fl,
                       input bit ordy, input bit er, input bit eov, input int ecnt);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = ctl(d);
        stall     = st;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(eov));
        chk("stall_cnt", 64'(stall_cnt), 64'(ecnt));
        if (!eov) chk("bubble_ctrl", 64'(out_ctrl), 64'(BUB));
        if (iv && er) sb.push_back('{c: ctl(d), d: d});
        @(posedge clk);
        #1;
        if (fl || !rst) sb.delete();
    endtask

    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got data %0h expected no output", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
                end
            end
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset hold
        vec(0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_data", 64'(out_data), 64'd0);
        vec(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        // passthrough
        vec(1, 32'h4, 0, 0, 1, 1, 0, 0);
        vec(1, 32'h8, 0, 0, 1, 1, 1, 0);
        vec(1, 32'hC, 0, 0, 1, 1, 1, 0);
        // load-use stall: one bubble
        vec(1, 32'h10, 0, 0, 1, 1, 1, 0);
        vec(1, 32'h14, 1, 0, 1, 0, 1, 0);
        vec(1, 32'h14, 0, 0, 1, 1, 0, 1);
        vec(0, 0,      0, 0, 1, 1, 1, 1);
        // backpressure for 3 cycles
        vec(1, 32'h42323, 0, 0, 1, 1, 0, 1);
        vec(0, 0, 0, 0, 0, SKID, 1, 1);
        vec(0, 0, 0, 0, 0, SKID, 1, 2);
        vec(0, 0, 0, 0, 0, SKID, 1, 3);
        vec(0, 0, 0, 0, 1, 1, 1, 4);
        vec(0, 0, 0, 0, 1, 1, 0, 4);
        // flush beats stall and accept; counter frozen
        vec(1, 32'h3765, 1, 1, 1, 0, 0, 4);
        vec(0, 0, 0, 0, 1, 1, 0, 4);
        // flush kills a held instruction
        vec(1, 32'h55, 0, 0, 0, 1, 0, 4);
        vec(0, 0, 0, 1, 0, 0, 1, 4);
        vec(0, 0, 0, 0, 1, 1, 0, 4);
        // saturation
        vec(1, 32'h99, 0, 0, 1, 1, 0, 4);
        for (int k = 0; k < 20; k++)
            vec(0, 0, 0, 0, 0, SKID, 1, (4 + k > 15) ? 15 : 4 + k);
        vec(0, 0, 0, 0, 1, 1, 1, 15);
        vec(0, 0, 0, 0, 1, 1, 0, 15);
        // skid ordering (base build holds 0xA4 upstream instead)
        vec(1, 32'hA0, 0, 0, 0, 1, 0, 15);
        vec(1, 32'hA4, 0, 0, 0, SKID, 1, 15);
        vec(1, 32'hA4, 0, 0, 0, 0, 1, 15);
        vec(1, 32'hA4, 0, 0, 1, !SKID, 1, 15);
        vec(0, 0, 0, 0, 1, 1, 1, 15);
        vec(0, 0, 0, 0, 1, 1, 0, 15);
        // reset mid-transfer
        vec(1, 32'hBB, 0, 0, 0, 1, 0, 15);
        rst = 1'b0;
        vec(0, 0, 0, 0, 0, 0, 1, 15);
        rst = 1'b1;
        vec(0, 0, 0, 0, 1, 1, 0, 0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
